// File: rtl/hazard_if.sv
// -----------------------------------------------------------------------------
// hazard_if -- pipeline <-> hazard controller signal bundle.
//
// Groups everything the hazard controller observes in ID/EX/MEM, the
// data-memory handshake, and every stall/flush/status output it drives.
//   slave  : hazard_ctrl side (observes stages, drives controls)
//   master : pipeline side (drives stage info, consumes controls)
//
// Stage inputs : rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, read_mem_ex,
//                branch_taken_ex, read_mem_mem, write_mem_mem
// Handshake    : dmem_req (out), dmem_ready (in)
// Controls     : pc/if_id/id_ex/ex_mem stalls, if_id/id_ex/mem_wb flushes
// Status       : mem_timeout_err, state, stall_cnt, flush_cnt
// -----------------------------------------------------------------------------
interface hazard_if;
   logic [4:0]  rs1_id;
   logic [4:0]  rs2_id;
   logic        use_rs1_id;
   logic        use_rs2_id;
   logic [4:0]  rd_ex;
   logic        read_mem_ex;
   logic        branch_taken_ex;
   logic        read_mem_mem;
   logic        write_mem_mem;
   logic        dmem_ready;
   logic        dmem_req;
   logic        pc_stall;
   logic        if_id_stall;
   logic        id_ex_stall;
   logic        ex_mem_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        mem_wb_flush;
   logic        mem_timeout_err;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport slave (
      input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, read_mem_ex,
             branch_taken_ex, read_mem_mem, write_mem_mem, dmem_ready,
      output dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err, state,
             stall_cnt, flush_cnt
   );

   modport master (
      output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, read_mem_ex,
             branch_taken_ex, read_mem_mem, write_mem_mem, dmem_ready,
      input  dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err, state,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- stall/flush sequencer for the 5-stage RISC-V pipeline.
//
// Resolves load-use hazards (one bubble), taken-branch redirects (flush IF/ID
// and ID/EX) and multi-cycle data-memory accesses (freeze PC..EX/MEM, bubble
// MEM/WB) with a wait-cycle timeout that parks the pipeline in ERR until reset.
// Stall/flush/dmem_req are combinational from inputs and state; state, wait
// counter, error flag and the saturating perf counters are registered.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : hazard_if.slave bundle (stage info in, controls/status out)
// Parameter:
//   MEM_TIMEOUT : MEM_WAIT cycles without dmem_ready before ERR (1..255)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic     clk,
   input  logic     rst_n,
   hazard_if.slave  hz
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t      r_state;
   logic [7:0]  r_wait_cnt;
   logic        r_timeout_err;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   logic w_mem_acc;
   logic w_load_use;
   logic w_mem_stall;
   logic w_dmem_req;
   logic w_branch_flush;
   logic w_lu_stall;
   logic w_pc_stall;

   // NOTE: every always_comb output gets a default before the case so that no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_mem_acc  = hz.read_mem_mem | hz.write_mem_mem;
      w_load_use = hz.read_mem_ex & (hz.rd_ex != 5'd0) &
                   ((hz.use_rs1_id & (hz.rs1_id == hz.rd_ex)) |
                    (hz.use_rs2_id & (hz.rs2_id == hz.rd_ex)));
      w_mem_stall = 1'b0;
      w_dmem_req  = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_dmem_req  = w_mem_acc;
            w_mem_stall = w_mem_acc & ~hz.dmem_ready;
         end
         ST_MEM_WAIT: begin
            // On the ready cycle the access is done, so branch/load-use
            // resolve in this same cycle exactly as they would in RUN.
            w_dmem_req  = 1'b1;
            w_mem_stall = ~hz.dmem_ready;
         end
         ST_ERR: w_mem_stall = 1'b1;
         default: ;
      endcase
      // Memory stall dominates: the EX instruction is frozen, so branch and
      // load-use get re-evaluated once the stall releases.
      w_branch_flush = ~w_mem_stall & hz.branch_taken_ex;
      w_lu_stall     = ~w_mem_stall & ~hz.branch_taken_ex & w_load_use;
      w_pc_stall     = w_mem_stall | w_lu_stall;
   end

   assign hz.dmem_req        = w_dmem_req;
   assign hz.pc_stall        = w_pc_stall;
   assign hz.if_id_stall     = w_pc_stall;
   assign hz.id_ex_stall     = w_mem_stall;
   assign hz.ex_mem_stall    = w_mem_stall;
   assign hz.if_id_flush     = w_branch_flush;
   assign hz.id_ex_flush     = w_branch_flush | w_lu_stall;
   assign hz.mem_wb_flush    = w_mem_stall;
   assign hz.mem_timeout_err = r_timeout_err;
   assign hz.state           = r_state;
   assign hz.stall_cnt       = r_stall_cnt;
   assign hz.flush_cnt       = r_flush_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: all state here is control (no memory arrays), so every register is
   // reset; ERR is only left through rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= 8'd0;
         r_timeout_err <= 1'b0;
         r_stall_cnt   <= 16'd0;
         r_flush_cnt   <= 16'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_acc && !hz.dmem_ready) begin
                  r_state    <= ST_MEM_WAIT;
                  r_wait_cnt <= 8'd1;
               end
            end
            ST_MEM_WAIT: begin
               if (hz.dmem_ready) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= 8'd0;
               end else if (r_wait_cnt == TIMEOUT_CNT) begin
                  r_state       <= ST_ERR;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            ST_ERR: ;
            default: r_state <= ST_RUN;
         endcase

         if (w_pc_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_branch_flush && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl (MEM_TIMEOUT = 15).
// Single-cycle RUN-state vectors come from a table; multi-cycle memory-wait,
// timeout, async-reset and counter-saturation cases are hand-written
// sequences. Expected control patterns are queued when inputs are driven and
// popped/compared when outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;
   hazard_if hz ();

   hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd_ex;
      logic       rmem_ex;
      logic       br;
      logic       rmem_mem;
      logic       wmem_mem;
      logic       ready;
   } in_t;

   typedef struct packed {
      in_t        in;
      logic [7:0] ctl;
   } vec_t;

   typedef struct packed {
      logic [7:0] ctl;
      logic [1:0] st;
   } exp_t;

   // ctl bit order: dmem_req, pc_stall, if_id_stall, id_ex_stall,
   //                ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush
   localparam logic [7:0] C_IDLE   = 8'b0000_0000;
   localparam logic [7:0] C_LU     = 8'b0110_0010;
   localparam logic [7:0] C_BR     = 8'b0000_0110;
   localparam logic [7:0] C_MEMST  = 8'b1111_1001;
   localparam logic [7:0] C_ERR    = 8'b0111_1001;
   localparam logic [7:0] C_REQ    = 8'b1000_0000;
   localparam logic [7:0] C_REQ_LU = 8'b1110_0010;
   localparam logic [7:0] C_REQ_BR = 8'b1000_0110;

   //                        rs1   rs2   u1 u2 rd    lx br rm wm rdy
   localparam in_t I_IDLE  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0};
   localparam in_t I_LU    = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 1};
   localparam in_t I_LU_R0 = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 1};
   localparam in_t I_MEM   = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0};
   localparam in_t I_MEMRD = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1};
   localparam in_t I_MBR   = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 0};
   localparam in_t I_MBRRD = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 1};
   localparam in_t I_ERRIN = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, 1};

   int total = 0;
   int bad   = 0;
   exp_t  exp_q[$];
   string name_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] act_ctl();
      return {hz.dmem_req, hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
              hz.ex_mem_stall, hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush};
   endfunction

   task automatic drive(input in_t v);
      hz.rs1_id          = v.rs1;
      hz.rs2_id          = v.rs2;
      hz.use_rs1_id      = v.use1;
      hz.use_rs2_id      = v.use2;
      hz.rd_ex           = v.rd_ex;
      hz.read_mem_ex     = v.rmem_ex;
      hz.branch_taken_ex = v.br;
      hz.read_mem_mem    = v.rmem_mem;
      hz.write_mem_mem   = v.wmem_mem;
      hz.dmem_ready      = v.ready;
   endtask

   // One clock cycle: drive just after the rising edge, push the expectation,
   // pop and compare at the falling edge, then advance past the next edge.
   task automatic step(input in_t v, input logic [7:0] ctl,
                       input logic [1:0] st, input string name);
      exp_t e;
      string n;
      drive(v);
      exp_q.push_back('{ctl: ctl, st: st});
      name_q.push_back(name);
      @(negedge clk);
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".ctl"}, 32'(act_ctl()), 32'(e.ctl));
      check({n, ".state"}, 32'(hz.state), 32'(e.st));
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset applied mid-cycle; checked before any clock edge.
   task automatic do_reset(input string name);
      drive(I_IDLE);
      rst_n = 1'b0;
      #2;
      check({name, ".rst_ctl"}, 32'(act_ctl()), 32'(C_IDLE));
      check({name, ".rst_state"}, 32'(hz.state), 32'd0);
      check({name, ".rst_err"}, 32'(hz.mem_timeout_err), 32'd0);
      check({name, ".rst_scnt"}, 32'(hz.stall_cnt), 32'd0);
      check({name, ".rst_fcnt"}, 32'(hz.flush_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Request that never completes: 1 RUN stall cycle + 15 MEM_WAIT cycles.
   task automatic run_to_err(input string name);
      step(I_MEM, C_MEMST, 2'd0, {name, ".req"});
      for (int i = 1; i <= 15; i++) begin
         if (i == 15)
            check({name, ".err_before"}, 32'(hz.mem_timeout_err), 32'd0);
         step(I_MEM, C_MEMST, 2'd1, $sformatf("%s.wait%0d", name, i));
      end
      check({name, ".err_set"}, 32'(hz.mem_timeout_err), 32'd1);
      check({name, ".err_state"}, 32'(hz.state), 32'd2);
   endtask

   vec_t vecs[11];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //               rs1   rs2   u1 u2 rd    lx br rm wm rdy     expected
      vecs[0]  = '{'{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0}, C_IDLE};   // idle
      vecs[1]  = '{'{5'd5, 5'd3, 1, 1, 5'd5, 1, 0, 0, 0, 0}, C_LU};     // rs1 hit
      vecs[2]  = '{'{5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0}, C_IDLE};   // rd x0
      vecs[3]  = '{'{5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, 0}, C_LU};     // rs2 hit
      vecs[4]  = '{'{5'd1, 5'd9, 1, 0, 5'd9, 1, 0, 0, 0, 0}, C_IDLE};   // rs2 unused
      vecs[5]  = '{'{5'd4, 5'd0, 1, 0, 5'd4, 0, 0, 0, 0, 0}, C_IDLE};   // not a load
      vecs[6]  = '{'{5'd6, 5'd0, 1, 0, 5'd6, 1, 1, 0, 0, 0}, C_BR};     // br > lu
      vecs[7]  = '{'{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0}, C_BR};     // branch
      vecs[8]  = '{'{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1}, C_REQ};    // 0-wait rd
      vecs[9]  = '{'{5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 0, 1, 1}, C_REQ_LU}; // 0-wait wr+lu
      vecs[10] = '{'{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 1}, C_REQ_BR}; // 0-wait+br

      rst_n = 1'b0;
      drive(I_IDLE);
      do_reset("init");

      // Single-cycle vectors, all in RUN.
      for (int i = 0; i < 11; i++)
         step(vecs[i].in, vecs[i].ctl, 2'd0, $sformatf("vec%0d", i));
      check("vec.stall_cnt", 32'(hz.stall_cnt), 32'd3);
      check("vec.flush_cnt", 32'(hz.flush_cnt), 32'd3);

      // Load-use: one bubble, then the load has moved on; rd=x0 never stalls.
      do_reset("lu");
      step(I_LU, C_LU, 2'd0, "lu.bubble");
      step(I_IDLE, C_IDLE, 2'd0, "lu.after");
      check("lu.stall_cnt", 32'(hz.stall_cnt), 32'd1);
      step(I_LU_R0, C_IDLE, 2'd0, "lu.x0");
      check("lu.x0_stall_cnt", 32'(hz.stall_cnt), 32'd1);

      // 3-wait read: 3 stall cycles, 4 cycles of dmem_req, 0->1->0.
      do_reset("w3");
      step(I_MEM, C_MEMST, 2'd0, "w3.c0");
      step(I_MEM, C_MEMST, 2'd1, "w3.c1");
      step(I_MEM, C_MEMST, 2'd1, "w3.c2");
      step(I_MEMRD, C_REQ, 2'd1, "w3.rel");
      step(I_IDLE, C_IDLE, 2'd0, "w3.after");
      check("w3.stall_cnt", 32'(hz.stall_cnt), 32'd3);

      // Branch held under a 2-wait access: flush only on release.
      do_reset("wb");
      step(I_MBR, C_MEMST, 2'd0, "wb.c0");
      step(I_MBR, C_MEMST, 2'd1, "wb.c1");
      step(I_MBRRD, C_REQ_BR, 2'd1, "wb.rel");
      step(I_IDLE, C_IDLE, 2'd0, "wb.after");
      check("wb.flush_cnt", 32'(hz.flush_cnt), 32'd1);
      check("wb.stall_cnt", 32'(hz.stall_cnt), 32'd2);

      // Ready on the last allowed MEM_WAIT cycle releases instead of ERR.
      do_reset("edge");
      step(I_MEM, C_MEMST, 2'd0, "edge.c0");
      for (int i = 1; i <= 14; i++)
         step(I_MEM, C_MEMST, 2'd1, $sformatf("edge.wait%0d", i));
      step(I_MEMRD, C_REQ, 2'd1, "edge.rel");
      step(I_IDLE, C_IDLE, 2'd0, "edge.after");
      check("edge.err", 32'(hz.mem_timeout_err), 32'd0);

      // Timeout into ERR; ERR ignores every input and only reset leaves it.
      do_reset("to");
      run_to_err("to");
      for (int i = 0; i < 3; i++)
         step(I_ERRIN, C_ERR, 2'd2, $sformatf("to.err%0d", i));
      check("to.stall_cnt", 32'(hz.stall_cnt), 32'd19);
      check("to.flush_cnt", 32'(hz.flush_cnt), 32'd0);

      // Asynchronous reset landing mid-MEM_WAIT.
      do_reset("mid");
      step(I_MEM, C_MEMST, 2'd0, "mid.c0");
      step(I_MEM, C_MEMST, 2'd1, "mid.c1");
      step(I_MEM, C_MEMST, 2'd1, "mid.c2");
      do_reset("mid_async");
      step(I_IDLE, C_IDLE, 2'd0, "mid.idle");

      // Saturation: sit in ERR for 70000 stall cycles.
      do_reset("sat");
      run_to_err("sat");
      drive(I_IDLE);
      repeat (70000) @(posedge clk);
      #1;
      check("sat.stall_cnt", 32'(hz.stall_cnt), 32'hFFFF);
      check("sat.state", 32'(hz.state), 32'd2);
      do_reset("sat_exit");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
